// File: rtl/led_panel_pkg.sv
// Shared LED panel definitions: sync marker, FSM state types and default geometry.
package led_panel_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  localparam int unsigned DEFAULT_ROWS      = 8;
  localparam int unsigned DEFAULT_ROW_BYTES = 3;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    P_SYNC,
    P_ROW,
    P_DATA,
    P_CSUM
  } parse_state_t;

  // Bits needed to index n items; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_frame_loader_if.sv
// Frame-buffer write port and error strobes driven by uart_frame_loader.
interface uart_frame_loader_if import led_panel_pkg::*; #(
  parameter int unsigned ROWS      = DEFAULT_ROWS,
  parameter int unsigned ROW_BYTES = DEFAULT_ROW_BYTES
) ();

  localparam int unsigned AW = idx_width(ROWS);

  logic                   fb_we;
  logic [AW-1:0]          fb_addr;
  logic [ROW_BYTES*8-1:0] fb_data;
  logic                   frame_done;
  logic                   err_framing;
  logic                   err_packet;

  modport master (
    output fb_we,
    output fb_addr,
    output fb_data,
    output frame_done,
    output err_framing,
    output err_packet
  );

  modport slave (
    input fb_we,
    input fb_addr,
    input fb_data,
    input frame_done,
    input err_framing,
    input err_packet
  );

endinterface

// File: rtl/uart_rx_core.sv
// 8N1 UART byte receiver: input synchroniser, mid-bit sampling FSM,
// one-cycle byte-valid and framing-error pulses.
module uart_rx_core import led_panel_pkg::*; #(
  parameter int unsigned CLKS_PER_BIT = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_framing_err
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  logic [1:0]    sync_q;
  logic          rx_s;
  logic          rx_prev_q;
  logic          fall;

  rx_state_t     state_q, state_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [2:0]    bit_q, bit_n;
  logic [7:0]    shreg_q, shreg_n;
  logic          valid_q, valid_n;
  logic          ferr_q, ferr_n;

  assign rx_s = sync_q[1];
  assign fall = rx_prev_q & ~rx_s;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q    <= '1;
      rx_prev_q <= 1'b1;
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], uart_data};
      rx_prev_q <= rx_s;
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      bit_q     <= bit_n;
      shreg_q   <= shreg_n;
      valid_q   <= valid_n;
      ferr_q    <= ferr_n;
    end
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    bit_n   = bit_q;
    shreg_n = shreg_q;
    valid_n = 1'b0;
    ferr_n  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (fall) begin
          state_n = RX_START;
          cnt_n   = '0;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          // Line back high at mid start bit: a glitch, not a start bit.
          cnt_n   = '0;
          bit_n   = '0;
          state_n = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_n   = '0;
          shreg_n = {rx_s, shreg_q[7:1]};
          bit_n   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_n = RX_STOP;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_n   = '0;
          state_n = RX_IDLE;
          if (rx_s) valid_n = 1'b1;
          else      ferr_n  = 1'b1;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      default: state_n = RX_IDLE;
    endcase
  end

  assign rx_byte        = shreg_q;
  assign rx_valid       = valid_q;
  assign rx_framing_err = ferr_q;

endmodule

// File: rtl/uart_frame_loader.sv
// UART row-packet loader: parses A5/row/data/csum packets and issues
// one-cycle frame-buffer row writes; bad packets are dropped whole.
module uart_frame_loader import led_panel_pkg::*; #(
  parameter int unsigned CLKS_PER_BIT = 20,
  parameter int unsigned ROWS         = DEFAULT_ROWS,
  parameter int unsigned ROW_BYTES    = DEFAULT_ROW_BYTES,
  parameter int unsigned TIMEOUT_BITS = 30
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                uart_data,
  uart_frame_loader_if.master fb
);

  localparam int unsigned AW      = idx_width(ROWS);
  localparam int unsigned BW      = idx_width(ROW_BYTES);
  localparam int unsigned DW      = ROW_BYTES * 8;
  localparam int unsigned TO_CLKS = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int unsigned TW      = $clog2(TO_CLKS + 1);

  logic [7:0]   rx_byte;
  logic         rx_valid;
  logic         rx_ferr;

  parse_state_t pstate_q, pstate_n;
  logic [AW-1:0] row_q, row_n;
  logic [7:0]    csum_q, csum_n;
  logic [DW-1:0] stage_q, stage_n;
  logic [BW-1:0] idx_q, idx_n;
  logic [TW-1:0] idle_q, idle_n;

  logic          fb_we_q, we_n;
  logic [AW-1:0] fb_addr_q, addr_n;
  logic [DW-1:0] fb_data_q, data_n;
  logic          frame_done_q, done_n;
  logic          err_framing_q;
  logic          err_packet_q, perr_n;

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk           (clk),
    .reset         (reset),
    .uart_data     (uart_data),
    .rx_byte       (rx_byte),
    .rx_valid      (rx_valid),
    .rx_framing_err(rx_ferr)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pstate_q      <= P_SYNC;
      row_q         <= '0;
      csum_q        <= '0;
      stage_q       <= '0;
      idx_q         <= '0;
      idle_q        <= '0;
      fb_we_q       <= 1'b0;
      fb_addr_q     <= '0;
      fb_data_q     <= '0;
      frame_done_q  <= 1'b0;
      err_framing_q <= 1'b0;
      err_packet_q  <= 1'b0;
    end else begin
      pstate_q      <= pstate_n;
      row_q         <= row_n;
      csum_q        <= csum_n;
      stage_q       <= stage_n;
      idx_q         <= idx_n;
      idle_q        <= idle_n;
      fb_we_q       <= we_n;
      fb_addr_q     <= addr_n;
      fb_data_q     <= data_n;
      frame_done_q  <= done_n;
      err_framing_q <= rx_ferr;
      err_packet_q  <= perr_n;
    end
  end

  // Framing error and byte-valid are mutually exclusive from the receiver;
  // packet errors are only raised when no framing error is present, which
  // keeps the two registered error strobes from pulsing together.
  always_comb begin
    pstate_n = pstate_q;
    row_n    = row_q;
    csum_n   = csum_q;
    stage_n  = stage_q;
    idx_n    = idx_q;
    idle_n   = idle_q;
    we_n     = 1'b0;
    addr_n   = fb_addr_q;
    data_n   = fb_data_q;
    done_n   = 1'b0;
    perr_n   = 1'b0;
    if (rx_ferr) begin
      pstate_n = P_SYNC;
      idle_n   = '0;
    end else if (rx_valid) begin
      idle_n = '0;
      case (pstate_q)
        P_SYNC: begin
          if (rx_byte == SYNC_BYTE) pstate_n = P_ROW;
        end
        P_ROW: begin
          if (32'(rx_byte) >= ROWS) begin
            perr_n   = 1'b1;
            pstate_n = P_SYNC;
          end else begin
            row_n    = rx_byte[AW-1:0];
            csum_n   = rx_byte;
            idx_n    = '0;
            pstate_n = P_DATA;
          end
        end
        P_DATA: begin
          for (int unsigned i = 0; i < ROW_BYTES; i++) begin
            if (idx_q == BW'(i)) stage_n[i*8 +: 8] = rx_byte;
          end
          csum_n = csum_q ^ rx_byte;
          if (idx_q == BW'(ROW_BYTES - 1)) pstate_n = P_CSUM;
          else                             idx_n    = idx_q + 1'b1;
        end
        P_CSUM: begin
          if (rx_byte == csum_q) begin
            we_n   = 1'b1;
            addr_n = row_q;
            data_n = stage_q;
            done_n = (row_q == AW'(ROWS - 1));
          end else begin
            perr_n = 1'b1;
          end
          pstate_n = P_SYNC;
        end
        default: pstate_n = P_SYNC;
      endcase
    end else if (pstate_q != P_SYNC) begin
      if (idle_q == TW'(TO_CLKS - 1)) begin
        perr_n   = 1'b1;
        pstate_n = P_SYNC;
        idle_n   = '0;
      end else begin
        idle_n = idle_q + 1'b1;
      end
    end
  end

  assign fb.fb_we       = fb_we_q;
  assign fb.fb_addr     = fb_addr_q;
  assign fb.fb_data     = fb_data_q;
  assign fb.frame_done  = frame_done_q;
  assign fb.err_framing = err_framing_q;
  assign fb.err_packet  = err_packet_q;

endmodule
